// File: rtl/uvmt_cv32e40s_obi_rchk_gen_if.sv
// OBI address and response signals seen by the rchk generator.
// The master side is the memory agent; the slave side is the generator.
interface uvmt_cv32e40s_obi_rchk_gen_if;
    logic        req_i;
    logic        gnt_i;
    logic [31:0] addr_i;
    logic        dbg_i;
    logic        rvalid_i;
    logic [31:0] rdata_i;
    logic        err_i;
    logic [4:0]  rchk_i;
    logic [4:0]  rchk_o;

    modport master (
        output req_i, gnt_i, addr_i, dbg_i, rvalid_i, rdata_i, err_i, rchk_i,
        input  rchk_o
    );

    modport slave (
        input  req_i, gnt_i, addr_i, dbg_i, rvalid_i, rdata_i, err_i, rchk_i,
        output rchk_o
    );
endinterface

// File: rtl/uvmt_cv32e40s_obi_rchk_gen.sv
// OBI response-integrity (rchk) generator.
// Records an integrity class for every granted request in a circular FIFO.
// Drives rchk for each response from that class, the response data and the
// selected mode. Supports single-bit fault injection and sticky
// overflow/underflow flags.
module uvmt_cv32e40s_obi_rchk_gen #(
    parameter int                           MAX_OUTSTANDING  = 4,
    parameter int                           NUM_REGIONS      = 2,
    parameter logic [NUM_REGIONS-1:0][31:0] REGION_BASE      = {NUM_REGIONS{32'h0}},
    parameter logic [NUM_REGIONS-1:0][31:0] REGION_MASK      = {NUM_REGIONS{32'h0}},
    parameter bit                           DBG_IS_INTEGRITY = 1'b1,
    localparam int                          CNT_W            = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    uvmt_cv32e40s_obi_rchk_gen_if.slave obi,
    input  logic [1:0]                  mode_i,
    input  logic [15:0]                 corrupt_idx_i,
    input  logic [2:0]                  corrupt_bit_i,
    output logic [CNT_W-1:0]            outstanding_o,
    output logic                        overflow_o,
    output logic                        underflow_o,
    output logic                        corrupted_o
);

    localparam int               PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

    typedef enum logic [1:0] {
        MODE_PASS          = 2'd0,
        MODE_GEN_ALL       = 2'd1,
        MODE_GEN_INTEGRITY = 2'd2,
        MODE_CORRUPT       = 2'd3
    } mode_e;

    logic             fifo_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] occupancy;
    logic [15:0]      resp_cnt;

    mode_e            mode;
    logic             push, pop, full, empty, push_ok, pop_ok;
    logic             new_integ, head_integ, idx_hit;
    logic [4:0]       gen, flip_mask;
    logic [2:0]       bit_sel;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign mode       = mode_e'(mode_i);
    assign push       = obi.req_i & obi.gnt_i;
    assign pop        = obi.rvalid_i;
    assign full       = (occupancy == FULL_CNT);
    assign empty      = (occupancy == '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok    = push & (~full | pop);
    assign pop_ok     = pop & ~empty;
    // An underflowing response has no entry to consult and is non-integrity.
    assign head_integ = empty ? 1'b0 : fifo_mem[rd_ptr];

    assign bit_sel    = (corrupt_bit_i >= 3'd5) ? 3'd0 : corrupt_bit_i;
    assign flip_mask  = 5'b00001 << bit_sel;
    assign idx_hit    = (resp_cnt == corrupt_idx_i);

    assign outstanding_o = occupancy;

    // Classify the requested address: debug access or any region hit.
    always_comb begin
        // NOTE: assign every always_comb output first so no path leaves it unassigned (a latch).
        new_integ = obi.dbg_i & DBG_IS_INTEGRITY;
        for (int k = 0; k < NUM_REGIONS; k++) begin
            if ((obi.addr_i & REGION_MASK[k]) == REGION_BASE[k]) begin
                new_integ = 1'b1;
            end
        end
    end

    // Per-byte parity of the response data plus the error bit.
    always_comb begin
        gen = '0;
        for (int i = 0; i < 4; i++) begin
            gen[i] = ^obi.rdata_i[8*i +: 8];
        end
        gen[4] = obi.err_i;
    end

    // Select the rchk value for the current response; quiet outside responses and in reset.
    always_comb begin
        obi.rchk_o  = '0;
        corrupted_o = 1'b0;
        if (!rst && obi.rvalid_i) begin
            case (mode)
                MODE_PASS:          obi.rchk_o = obi.rchk_i;
                MODE_GEN_ALL:       obi.rchk_o = gen;
                MODE_GEN_INTEGRITY: obi.rchk_o = head_integ ? gen : obi.rchk_i;
                MODE_CORRUPT: begin
                    obi.rchk_o  = idx_hit ? (gen ^ flip_mask) : gen;
                    corrupted_o = idx_hit;
                end
            endcase
        end
    end

    // Pointers, occupancy, response counter and sticky flags.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occupancy   <= '0;
            resp_cnt    <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push_ok, pop_ok})
                2'b10:   occupancy <= occupancy + CNT_W'(1);
                2'b01:   occupancy <= occupancy - CNT_W'(1);
                default: occupancy <= occupancy;
            endcase
            if (pop)                  resp_cnt    <= resp_cnt + 16'd1;
            if (push && full && !pop) overflow_o  <= 1'b1;
            if (pop && empty)         underflow_o <= 1'b1;
        end
    end

    // Entry storage; validity is tracked by the pointers and occupancy alone.
    always_ff @(posedge clk) begin
        // NOTE: the entries are deliberately not reset; stale data is never read while empty.
        if (!rst && push_ok) begin
            fifo_mem[wr_ptr] <= new_integ;
        end
    end

endmodule

// File: tb/tb_uvmt_cv32e40s_obi_rchk_gen.sv
// Bench for the OBI rchk generator: a directed vector table covering the
// documented scenarios, then randomized traffic checked against a queue model.
module tb_uvmt_cv32e40s_obi_rchk_gen;

    localparam logic [1:0][31:0] BASES = {32'h8000_0000, 32'h1000_0000};
    localparam logic [1:0][31:0] MASKS = {32'hFFFF_0000, 32'hF000_0000};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Stimulus shared by the bench; sel routes the OBI signals to one instance.
    bit          sel;
    logic        s_req, s_gnt, s_dbg, s_rvalid, s_err;
    logic [31:0] s_addr, s_rdata;
    logic [4:0]  s_rchk;
    logic [1:0]  s_mode;
    logic [15:0] s_cidx;
    logic [2:0]  s_cbit;

    uvmt_cv32e40s_obi_rchk_gen_if if_a ();
    uvmt_cv32e40s_obi_rchk_gen_if if_b ();

    assign if_a.req_i    = !sel && s_req;
    assign if_a.gnt_i    = !sel && s_gnt;
    assign if_a.addr_i   = sel ? '0 : s_addr;
    assign if_a.dbg_i    = !sel && s_dbg;
    assign if_a.rvalid_i = !sel && s_rvalid;
    assign if_a.rdata_i  = sel ? '0 : s_rdata;
    assign if_a.err_i    = !sel && s_err;
    assign if_a.rchk_i   = sel ? '0 : s_rchk;

    assign if_b.req_i    = sel && s_req;
    assign if_b.gnt_i    = sel && s_gnt;
    assign if_b.addr_i   = sel ? s_addr : '0;
    assign if_b.dbg_i    = sel && s_dbg;
    assign if_b.rvalid_i = sel && s_rvalid;
    assign if_b.rdata_i  = sel ? s_rdata : '0;
    assign if_b.err_i    = sel && s_err;
    assign if_b.rchk_i   = sel ? s_rchk : '0;

    logic [2:0] out_a;
    logic [1:0] out_b;
    logic       ovf_a, udf_a, cor_a, ovf_b, udf_b, cor_b;

    uvmt_cv32e40s_obi_rchk_gen #(
        .MAX_OUTSTANDING(4), .NUM_REGIONS(2), .REGION_BASE(BASES),
        .REGION_MASK(MASKS), .DBG_IS_INTEGRITY(1'b1)
    ) dut_a (
        .clk(clk), .rst(rst), .obi(if_a), .mode_i(s_mode),
        .corrupt_idx_i(s_cidx), .corrupt_bit_i(s_cbit),
        .outstanding_o(out_a), .overflow_o(ovf_a), .underflow_o(udf_a),
        .corrupted_o(cor_a)
    );

    uvmt_cv32e40s_obi_rchk_gen #(
        .MAX_OUTSTANDING(2), .NUM_REGIONS(2), .REGION_BASE(BASES),
        .REGION_MASK(MASKS), .DBG_IS_INTEGRITY(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst), .obi(if_b), .mode_i(s_mode),
        .corrupt_idx_i(s_cidx), .corrupt_bit_i(s_cbit),
        .outstanding_o(out_b), .overflow_o(ovf_b), .underflow_o(udf_b),
        .corrupted_o(cor_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (queue of integrity classes) ----------------
    bit m_q[$];
    int m_cnt;
    bit m_ovf, m_udf;

    function automatic bit m_classify(input logic [31:0] a, input logic d);
        if (d) return 1'b1;
        for (int k = 0; k < 2; k++) begin
            if ((a & MASKS[k]) == BASES[k]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [4:0] m_gen(input logic [31:0] data, input logic e);
        logic [4:0]  g;
        logic [31:0] w;
        for (int i = 0; i < 4; i++) begin
            w    = data >> (8 * i);
            g[i] = ($countones(w[7:0]) % 2) == 1;
        end
        g[4] = e;
        return g;
    endfunction

    task automatic m_expect(output logic [4:0] r, output logic c);
        int         bsel;
        bit         integ;
        logic [4:0] g;
        r = '0;
        c = 1'b0;
        if (rst || !s_rvalid) return;
        bsel  = (s_cbit >= 5) ? 0 : int'(s_cbit);
        integ = (m_q.size() > 0) ? m_q[0] : 1'b0;
        g     = m_gen(s_rdata, s_err);
        case (s_mode)
            2'd0: r = s_rchk;
            2'd1: r = g;
            2'd2: r = integ ? g : s_rchk;
            default: begin
                c = (m_cnt == int'(s_cidx));
                r = c ? (g ^ (5'b00001 << bsel)) : g;
            end
        endcase
    endtask

    task automatic m_update();
        int depth;
        bit full_before, empty_before;
        if (rst) begin
            m_q.delete();
            m_cnt = 0;
            m_ovf = 0;
            m_udf = 0;
            return;
        end
        depth        = sel ? 2 : 4;
        full_before  = (m_q.size() == depth);
        empty_before = (m_q.size() == 0);
        if (s_rvalid) begin
            if (empty_before) m_udf = 1;
            else void'(m_q.pop_front());
            m_cnt = (m_cnt + 1) % 65536;
        end
        if (s_req && s_gnt) begin
            if (full_before && !s_rvalid) m_ovf = 1;
            else m_q.push_back(m_classify(s_addr, s_dbg));
        end
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        bit          sel;
        logic        rst;
        logic [1:0]  mode;
        logic [15:0] cidx;
        logic [2:0]  cbit;
        logic        req, gnt;
        logic [31:0] addr;
        logic        dbg, rvalid;
        logic [31:0] rdata;
        logic        err;
        logic [4:0]  rchk;
        logic [4:0]  exp_rchk;
        logic        exp_cor;
        int          exp_out;
        logic        exp_ovf, exp_udf;
    } vec_t;

    vec_t tab[$];

    function automatic vec_t mk(bit se, logic rs, logic [1:0] mo, logic [15:0] ci, logic [2:0] cb,
                                logic rq, logic gn, logic [31:0] ad, logic db,
                                logic rv, logic [31:0] rd, logic er, logic [4:0] rc,
                                logic [4:0] xr, logic xc, int xo, logic xov, logic xud);
        vec_t v;
        v.sel = se; v.rst = rs; v.mode = mo; v.cidx = ci; v.cbit = cb;
        v.req = rq; v.gnt = gn; v.addr = ad; v.dbg = db;
        v.rvalid = rv; v.rdata = rd; v.err = er; v.rchk = rc;
        v.exp_rchk = xr; v.exp_cor = xc; v.exp_out = xo; v.exp_ovf = xov; v.exp_udf = xud;
        return v;
    endfunction

    function automatic logic [4:0] act_rchk();
        return sel ? if_b.rchk_o : if_a.rchk_o;
    endfunction

    // Drive one cycle, check combinational outputs mid-cycle and registered ones after the edge.
    task automatic apply(input vec_t v, input bit directed, input string tag);
        logic [4:0] er;
        logic       ec;
        sel = v.sel; rst = v.rst; s_mode = v.mode; s_cidx = v.cidx; s_cbit = v.cbit;
        s_req = v.req; s_gnt = v.gnt; s_addr = v.addr; s_dbg = v.dbg;
        s_rvalid = v.rvalid; s_rdata = v.rdata; s_err = v.err; s_rchk = v.rchk;
        #2;
        m_expect(er, ec);
        if (directed) begin
            er = v.exp_rchk;
            ec = v.exp_cor;
        end
        check({tag, " rchk_o"}, 32'(act_rchk()), 32'(er));
        check({tag, " corrupted_o"}, 32'(sel ? cor_b : cor_a), 32'(ec));
        @(posedge clk);
        m_update();
        @(negedge clk);
        #1;
        check({tag, " outstanding_o"}, sel ? 32'(out_b) : 32'(out_a),
              directed ? 32'(v.exp_out) : 32'(m_q.size()));
        check({tag, " overflow_o"}, 32'(sel ? ovf_b : ovf_a), 32'(directed ? v.exp_ovf : m_ovf));
        check({tag, " underflow_o"}, 32'(sel ? udf_b : udf_a), 32'(directed ? v.exp_udf : m_udf));
    endtask

    localparam logic [31:0] RD_A = 32'h0103_00FF;  // byte parities FF:0 00:0 03:0 01:1

    initial begin
        vec_t v;
        sel = 0; rst = 1; s_mode = 0; s_cidx = 0; s_cbit = 0;
        s_req = 0; s_gnt = 0; s_addr = 0; s_dbg = 0;
        s_rvalid = 0; s_rdata = 0; s_err = 0; s_rchk = 0;
        @(negedge clk);

        // GEN_ALL, depth 4: reset with a response present, four grants, four responses.
        tab.push_back(mk(0,1,1,0,0, 0,0,0,0, 1,RD_A,0,5'h1F, 5'h00,0, 0,0,0));
        for (int k = 1; k <= 4; k++)
            tab.push_back(mk(0,0,1,0,0, 1,1,32'h3000_0000,0, 0,0,0,0, 5'h00,0, k,0,0));
        for (int k = 1; k <= 4; k++)
            tab.push_back(mk(0,0,1,0,0, 0,0,0,0, 1,RD_A,0,5'h1F, 5'b01000,0, 4-k,0,0));

        // CORRUPT: reset forces outputs low even when the index matches the pre-reset count.
        tab.push_back(mk(0,1,3,4,4, 0,0,0,0, 1,0,0,0, 5'h00,0, 0,0,0));
        tab.push_back(mk(0,0,3,2,4, 0,0,0,0, 1,0,0,5'h1F, 5'h00,0, 0,0,1));
        tab.push_back(mk(0,0,3,2,4, 0,0,0,0, 1,0,0,5'h1F, 5'h00,0, 0,0,1));
        tab.push_back(mk(0,0,3,2,4, 0,0,0,0, 1,0,0,5'h1F, 5'b10000,1, 0,0,1));
        tab.push_back(mk(0,0,3,3,6, 0,0,0,0, 1,0,0,5'h1F, 5'b00001,1, 0,0,1));
        tab.push_back(mk(0,0,3,3,6, 0,0,0,0, 1,0,0,5'h1F, 5'h00,0, 0,0,1));

        // GEN_INTEGRITY: region 0 hit, miss, debug, region 1 hit, request without grant.
        tab.push_back(mk(0,1,2,0,0, 0,0,0,0, 0,0,0,0, 5'h00,0, 0,0,0));
        tab.push_back(mk(0,0,2,0,0, 1,1,32'h1000_0040,0, 0,0,0,5'h1F, 5'h00,0, 1,0,0));
        tab.push_back(mk(0,0,2,0,0, 1,1,32'h2000_0000,0, 0,0,0,5'h1F, 5'h00,0, 2,0,0));
        tab.push_back(mk(0,0,2,0,0, 0,0,0,0, 1,32'h0000_0001,0,5'h1F, 5'h01,0, 1,0,0));
        tab.push_back(mk(0,0,2,0,0, 0,0,0,0, 1,32'h0000_0001,0,5'h1F, 5'h1F,0, 0,0,0));
        tab.push_back(mk(0,0,2,0,0, 1,1,32'h2000_0000,1, 0,0,0,5'h1F, 5'h00,0, 1,0,0));
        tab.push_back(mk(0,0,2,0,0, 0,0,0,0, 1,32'h0000_0100,1,5'h1F, 5'b10010,0, 0,0,0));
        tab.push_back(mk(0,0,2,0,0, 1,1,32'h8000_1234,0, 0,0,0,0, 5'h00,0, 1,0,0));
        tab.push_back(mk(0,0,2,0,0, 0,0,0,0, 1,32'h8000_0000,0,5'h00, 5'b01000,0, 0,0,0));
        tab.push_back(mk(0,0,2,0,0, 1,0,32'h1000_0000,0, 0,0,0,0, 5'h00,0, 0,0,0));
        tab.push_back(mk(0,0,2,0,0, 0,0,0,0, 1,32'h0000_0001,0,5'h15, 5'h15,0, 0,0,1));

        // Full boundary, depth 2: push+pop while full, then a dropped push.
        tab.push_back(mk(1,1,1,0,0, 0,0,0,0, 0,0,0,0, 5'h00,0, 0,0,0));
        tab.push_back(mk(1,0,1,0,0, 1,1,32'h3000_0000,0, 0,0,0,0, 5'h00,0, 1,0,0));
        tab.push_back(mk(1,0,1,0,0, 1,1,32'h3000_0000,0, 0,0,0,0, 5'h00,0, 2,0,0));
        tab.push_back(mk(1,0,1,0,0, 1,1,32'h3000_0000,0, 1,0,0,5'h1F, 5'h00,0, 2,0,0));
        tab.push_back(mk(1,0,1,0,0, 1,1,32'h3000_0000,0, 0,0,0,0, 5'h00,0, 2,1,0));
        tab.push_back(mk(1,0,1,0,0, 0,0,0,0, 1,32'h0000_00FF,0,0, 5'h00,0, 1,1,0));
        tab.push_back(mk(1,0,1,0,0, 0,0,0,0, 1,0,0,0, 5'h00,0, 0,1,0));
        tab.push_back(mk(1,0,1,0,0, 0,0,0,0, 1,0,0,0, 5'h00,0, 0,1,1));

        // Reset mid-operation, then underflow and the counter restarting from zero.
        tab.push_back(mk(0,1,1,0,0, 0,0,0,0, 0,0,0,0, 5'h00,0, 0,0,0));
        for (int k = 1; k <= 3; k++)
            tab.push_back(mk(0,0,1,0,0, 1,1,32'h1000_0000,0, 0,0,0,0, 5'h00,0, k,0,0));
        tab.push_back(mk(0,1,1,0,0, 0,0,0,0, 0,0,0,0, 5'h00,0, 0,0,0));
        tab.push_back(mk(0,0,2,0,0, 0,0,0,0, 1,32'hFFFF_FFFF,0,5'h0A, 5'h0A,0, 0,0,1));
        tab.push_back(mk(0,0,3,1,0, 0,0,0,0, 1,0,0,0, 5'b00001,1, 0,0,1));
        // Underflow with a simultaneous push: the push is kept for the next response.
        tab.push_back(mk(0,0,2,0,0, 1,1,32'h1000_0000,0, 1,0,0,5'h03, 5'h03,0, 1,0,1));
        tab.push_back(mk(0,0,2,0,0, 0,0,0,0, 1,32'h0000_0001,0,5'h00, 5'h01,0, 0,0,1));

        foreach (tab[i]) apply(tab[i], 1'b1, $sformatf("vec%0d", i));

        // Randomized traffic on each instance against the model.
        for (int seg = 0; seg < 2; seg++) begin
            for (int n = 0; n < 600; n++) begin
                v.sel    = bit'(seg);
                v.rst    = (n == 0) || ($urandom_range(0, 99) == 0);
                v.mode   = 2'($urandom_range(0, 3));
                v.cidx   = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 40))
                                                       : 16'(m_cnt + int'($urandom_range(0, 2)));
                v.cbit   = 3'($urandom_range(0, 7));
                v.req    = 1'($urandom_range(0, 1));
                v.gnt    = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 3))
                    0:       v.addr = 32'h1000_0000 | 32'($urandom_range(0, 32'hFFFF));
                    1:       v.addr = 32'h8000_0000 | 32'($urandom_range(0, 32'hFFFF));
                    2:       v.addr = 32'h8001_0000;
                    default: v.addr = $urandom;
                endcase
                v.dbg    = ($urandom_range(0, 3) == 0);
                v.rvalid = 1'($urandom_range(0, 1));
                v.rdata  = $urandom;
                v.err    = 1'($urandom_range(0, 1));
                v.rchk   = 5'($urandom_range(0, 31));
                v.exp_rchk = '0; v.exp_cor = 0; v.exp_out = 0; v.exp_ovf = 0; v.exp_udf = 0;
                apply(v, 1'b0, $sformatf("rnd%0d_%0d", seg, n));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
